// File: rtl/card_reader_pkg.sv
// card_reader_pkg: MIX character codes, memory size and controller states (PAD exists only with CARD_READER_EOL_PAD_EN)
package card_reader_pkg;

    typedef logic [5:0] mix_char_t;

    localparam int MEM_SIZE = 4000;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    localparam mix_char_t MIX_SPACE  = 6'd0;
    localparam mix_char_t MIX_A      = 6'd1;
    localparam mix_char_t MIX_J      = 6'd11;
    localparam mix_char_t MIX_S      = 6'd22;
    localparam mix_char_t MIX_ZERO   = 6'd30;
    localparam mix_char_t MIX_PERIOD = 6'd40;
    localparam mix_char_t MIX_COMMA  = 6'd41;
    localparam mix_char_t MIX_LPAREN = 6'd42;
    localparam mix_char_t MIX_RPAREN = 6'd43;
    localparam mix_char_t MIX_PLUS   = 6'd44;
    localparam mix_char_t MIX_MINUS  = 6'd45;
    localparam mix_char_t MIX_STAR   = 6'd46;
    localparam mix_char_t MIX_SLASH  = 6'd47;
    localparam mix_char_t MIX_EQUAL  = 6'd48;
    localparam mix_char_t MIX_DOLLAR = 6'd49;
    localparam mix_char_t MIX_LT     = 6'd50;
    localparam mix_char_t MIX_GT     = 6'd51;
    localparam mix_char_t MIX_AT     = 6'd52;
    localparam mix_char_t MIX_SEMI   = 6'd53;
    localparam mix_char_t MIX_COLON  = 6'd54;
    localparam mix_char_t MIX_APOS   = 6'd55;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_STORE,
`ifdef CARD_READER_EOL_PAD_EN
        ST_PAD,
`endif
        ST_DONE
    } state_t;

endpackage

// File: rtl/card_reader_uart_rx.sv
// uart_rx: 8N1 receiver with 2-flop synchronizer, mid-bit sampling and stop-bit framing check
module uart_rx
    import card_reader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       ferr
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     state, state_n;
    logic [1:0]    sync;
    logic          rx_s, rx_prev, half, tick;
    logic [CW-1:0] baud;
    logic [2:0]    bitn;
    logic [7:0]    shift;

    assign rx_s = sync[1];
    assign half = baud == CW'(CLKS_PER_BIT / 2 - 1);
    assign tick = baud == CW'(CLKS_PER_BIT - 1);

    // bring rx into the clock domain and remember the last sample for falling-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sync    <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync    <= {sync[0], rx};
            rx_prev <= rx_s;
        end
    end

    // receiver state register
    always_ff @(posedge clk) begin
        state <= reset ? RX_IDLE : state_n;
    end

    // next state: edge-triggered start, mid-bit start re-check, eight data bits, one stop bit
    always_comb begin
        state_n = state;
        case (state)
            RX_IDLE:  if (rx_prev && !rx_s) state_n = RX_START;
            RX_START: if (half) state_n = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick && bitn == 3'd7) state_n = RX_STOP;
            RX_STOP:  if (tick) state_n = RX_IDLE;
            default:  state_n = RX_IDLE;
        endcase
    end

    // baud counter restarts on every state change so each later tick lands mid-bit
    always_ff @(posedge clk) begin
        if (reset) begin
            baud  <= '0;
            bitn  <= 3'd0;
            shift <= 8'd0;
            data  <= 8'd0;
            valid <= 1'b0;
            ferr  <= 1'b0;
        end else begin
            valid <= 1'b0;
            ferr  <= 1'b0;
            baud  <= (state == RX_IDLE || state != state_n || tick) ? '0 : baud + CW'(1);
            bitn  <= state == RX_DATA ? (tick ? bitn + 3'd1 : bitn) : 3'd0;
            if (state == RX_DATA && tick) shift <= {rx_s, shift[7:1]};
            if (state == RX_STOP && tick) begin
                data  <= shift;
                valid <= rx_s;
                ferr  <= !rx_s;
            end
        end
    end

endmodule

// File: rtl/card_reader.sv
// card_reader: UART card reader packing ASCII into MIX words, one 16-word block per start (LF padding with CARD_READER_EOL_PAD_EN)
module card_reader
    import card_reader_pkg::*;
#(
    parameter int CLKS_PER_BIT    = 104,
    parameter int WORDS_PER_BLOCK = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic        start,
    input  logic [11:0] addressin,
    output logic [11:0] addressout,
    output logic [29:0] out,
    output logic        store,
    output logic        stop,
    output logic        busy,
    output logic        err
);

    localparam int IW = $clog2(WORDS_PER_BLOCK);
    localparam logic [IW-1:0] LAST = IW'(WORDS_PER_BLOCK - 1);

    state_t      state, state_n;
    logic [7:0]  rx_byte;
    logic        rx_valid, rx_ferr;
    mix_char_t   ch_q;
    logic        ch_v;
    logic [11:0] base, addr;
    logic [12:0] sum;
    logic [IW-1:0] idx;
    logic [29:0] word;
    logic [2:0]  nchar;
`ifdef CARD_READER_EOL_PAD_EN
    logic        ch_lf, eol;
`endif

    function automatic mix_char_t to_mix(input logic [7:0] b);
        logic [7:0] u;
        logic [7:0] c;
        u = (b >= "a" && b <= "z") ? b - 8'h20 : b;
        case (u)
            ".":     c = {2'b00, MIX_PERIOD};
            ",":     c = {2'b00, MIX_COMMA};
            "(":     c = {2'b00, MIX_LPAREN};
            ")":     c = {2'b00, MIX_RPAREN};
            "+":     c = {2'b00, MIX_PLUS};
            "-":     c = {2'b00, MIX_MINUS};
            "*":     c = {2'b00, MIX_STAR};
            "/":     c = {2'b00, MIX_SLASH};
            "=":     c = {2'b00, MIX_EQUAL};
            "$":     c = {2'b00, MIX_DOLLAR};
            "<":     c = {2'b00, MIX_LT};
            ">":     c = {2'b00, MIX_GT};
            "@":     c = {2'b00, MIX_AT};
            ";":     c = {2'b00, MIX_SEMI};
            ":":     c = {2'b00, MIX_COLON};
            "'":     c = {2'b00, MIX_APOS};
            default: c = (u >= "A" && u <= "I") ? {2'b00, MIX_A} + (u - "A") :
                         (u >= "J" && u <= "R") ? {2'b00, MIX_J} + (u - "J") :
                         (u >= "S" && u <= "Z") ? {2'b00, MIX_S} + (u - "S") :
                         (u >= "0" && u <= "9") ? {2'b00, MIX_ZERO} + (u - "0") :
                                                  {2'b00, MIX_SPACE};
        endcase
        return c[5:0];
    endfunction

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .data  (rx_byte),
        .valid (rx_valid),
        .ferr  (rx_ferr)
    );

    assign sum        = {1'b0, base} + 13'(idx);
    assign addr       = sum >= 13'(MEM_SIZE) ? 12'(sum - 13'(MEM_SIZE)) : sum[11:0];
`ifdef CARD_READER_EOL_PAD_EN
    assign store      = state == ST_STORE || state == ST_PAD;
`else
    assign store      = state == ST_STORE;
`endif
    assign stop       = state == ST_DONE;
    assign busy       = state != ST_IDLE;
    assign out        = state == ST_STORE ? word : 30'd0;
    assign addressout = store ? addr : 12'd0;

    // controller state register
    always_ff @(posedge clk) begin
        state <= reset ? ST_IDLE : state_n;
    end

    // controller next state: collect five characters per word, store, finish after the last index
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (start) state_n = ST_RECV;
`ifdef CARD_READER_EOL_PAD_EN
            ST_RECV:  if (ch_lf) state_n = nchar == 3'd0 ? ST_PAD : ST_STORE;
                      else if (ch_v && nchar == 3'd4) state_n = ST_STORE;
            ST_STORE: state_n = idx == LAST ? ST_DONE : (eol ? ST_PAD : ST_RECV);
            ST_PAD:   state_n = idx == LAST ? ST_DONE : ST_PAD;
`else
            ST_RECV:  if (ch_v && nchar == 3'd4) state_n = ST_STORE;
            ST_STORE: state_n = idx == LAST ? ST_DONE : ST_RECV;
`endif
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // map each received byte one cycle after valid, then drop it into its slot of the word
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_q  <= MIX_SPACE;
            ch_v  <= 1'b0;
            base  <= 12'd0;
            idx   <= '0;
            word  <= 30'd0;
            nchar <= 3'd0;
            err   <= 1'b0;
`ifdef CARD_READER_EOL_PAD_EN
            ch_lf <= 1'b0;
            eol   <= 1'b0;
`endif
        end else begin
            ch_q <= to_mix(rx_byte);
            ch_v <= rx_valid && busy && rx_byte != ASCII_CR && rx_byte != ASCII_LF;
            err  <= (state == ST_IDLE && start) ? rx_ferr : err | rx_ferr;
`ifdef CARD_READER_EOL_PAD_EN
            ch_lf <= rx_valid && busy && rx_byte == ASCII_LF;
            if (state == ST_RECV && ch_lf) eol <= 1'b1;
            if (state == ST_IDLE && start) eol <= 1'b0;
`endif
            if (state == ST_IDLE && start) begin
                base  <= addressin;
                idx   <= '0;
                word  <= 30'd0;
                nchar <= 3'd0;
            end
            if (state == ST_RECV && ch_v) begin
                word[6 * (4 - int'(nchar)) +: 6] <= ch_q;
                nchar <= nchar + 3'd1;
            end
            if (store) begin
                word  <= 30'd0;
                nchar <= 3'd0;
                idx   <= idx + IW'(1);
            end
        end
    end

endmodule
